// File: rtl/serial_bla_sub_if.sv
// Operand/result handshake bundle for serial_bla_sub.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_bla_sub_if #(
  parameter int width = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] d;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_bla_sub.sv
// Nibble-serial borrow-lookahead subtractor: d = a - b - bin over width/4 cycles.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_bla_sub #(
  parameter int width = 32
) (
  input logic             clk,
  input logic             rst_n,
  serial_bla_sub_if.slave bus
);
  localparam int N  = width / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] KLAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [width-1:0] a_r;
  logic [width-1:0] b_r;
  logic             br;
  logic [CW-1:0]    k;
  logic [width-1:0] d_r;
  logic             bout_r;
  logic [3:0]       nib_diff;
  logic             br_next;
  logic [4:0]       nib_full;

  // Group borrow-out: generate/propagate lookahead across the four bits.
  function automatic logic nib_borrow(input logic [3:0] x, input logic [3:0] y, input logic bi);
    logic [3:0] g;
    logic [3:0] p;
    logic       gg;
    g  = ~x & y;
    p  = ~x | y;
    gg = g[3] | (p[3] & (g[2] | (p[2] & (g[1] | (p[1] & g[0])))));
    return gg | ((&p) & bi);
  endfunction

  // Borrow into bit 3 of the group, needed for the signed overflow term.
  function automatic logic msb_borrow(input logic [3:0] x, input logic [3:0] y, input logic bi);
    logic [3:0] g;
    logic [3:0] p;
    g = ~x & y;
    p = ~x | y;
    return g[2] | (p[2] & (g[1] | (p[1] & (g[0] | (p[0] & bi)))));
  endfunction

  // Operands are shifted right each cycle so the active nibble sits at [3:0].
  assign nib_full = {1'b0, a_r[3:0]} - {1'b0, b_r[3:0]} - {4'b0000, br};
  assign nib_diff = nib_full[3:0];
  assign br_next  = nib_borrow(a_r[3:0], b_r[3:0], br);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.d         = d_r;
  assign bus.bout      = bout_r;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_r;
  assign bus.ovf = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state == RUN && k == KLAST) begin
      ovf_r <= msb_borrow(a_r[3:0], b_r[3:0], br) ^ br_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      br     <= 1'b0;
      k      <= '0;
      d_r    <= '0;
      bout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            br    <= bus.bin;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          d_r[{k, 2'b00} +: 4] <= nib_diff;
          br  <= br_next;
          a_r <= a_r >> 4;
          b_r <= b_r >> 4;
          k   <= k + 1'b1;
          if (k == KLAST) begin
            bout_r <= br_next;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_bla_sub.sv
// Scoreboard bench for serial_bla_sub (width=32): stimulus pushes expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_serial_bla_sub;
  typedef struct packed {
    logic [31:0] d;
    logic        bout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  serial_bla_sub_if #(.width(32)) bus ();
  serial_bla_sub #(.width(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word integer arithmetic, no nibbles or lookahead.
  function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb, input logic bi);
    exp_t   e;
    longint u;
    longint s;
    u = longint'(aa) - longint'(bb) - longint'(bi);
    s = longint'($signed(aa)) - longint'($signed(bb)) - longint'(bi);
    e.d    = u[31:0];
    e.bout = (u < 0);
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got d=%0h with empty scoreboard", bus.d);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_d", 64'(bus.d), 64'(e.d));
        chk("sb_bout", 64'(bus.bout), 64'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
        chk("sb_ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
      end
    end
  end

  // Called #1 after an edge; returns at #1 after the accept edge.
  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic bi);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_in_ready", 64'(bus.in_ready), 64'd1);
    bus.a        = aa;
    bus.b        = bb;
    bus.bin      = bi;
    bus.in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(aa, bb, bi));
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  initial begin
    int          cyc;
    logic [31:0] hold_d;
    logic        hold_b;
    logic [31:0] xa;
    logic [31:0] xb;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_d", 64'(bus.d), 64'd0);
    chk("rst_bout", 64'(bus.bout), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic with latency check
    send(32'h5, 32'h3, 1'b0);
    wait_ov(cyc);
    chk("basic_latency", 64'(cyc), 64'd8);
    chk("basic_d", 64'(bus.d), 64'h2);
    chk("basic_bout", 64'(bus.bout), 64'd0);
    @(posedge clk); #1;

    send(32'h0, 32'h1, 1'b0);
    send(32'h1234_5678, 32'h1234_5678, 1'b1);
    send(32'h1234_5678, 32'h1234_5678, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    send(32'h8000_0000, 32'h1, 1'b0);
    send(32'h3, 32'h1, 1'b0);
`endif
    wait_ov(cyc);
    @(posedge clk); #1;

    // Back-pressure with a producer hammering in_valid
    bus.out_ready = 1'b0;
    send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    wait_ov(cyc);
    hold_d = bus.d;
    hold_b = bus.bout;
    for (int i = 0; i < 5; i++) begin
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.bin      = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_d", 64'(bus.d), 64'(hold_d));
      chk("bp_bout", 64'(bus.bout), 64'(hold_b));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    xa = $urandom;
    xb = $urandom;
    bus.a   = xa;
    bus.b   = xb;
    bus.bin = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_in_ready", 64'(bus.in_ready), 64'd1);
    chk("hs_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    sb.push_back(model(xa, xb, 1'b1));
    #1;
    bus.in_valid = 1'b0;
    chk("hs_next_accept", 64'(bus.in_ready), 64'd0);
    wait_ov(cyc);
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN
    send(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_d", 64'(bus.d), 64'd0);
    sb.delete();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h9, 32'h4, 1'b0);
    wait_ov(cyc);
    chk("post_rst_d", 64'(bus.d), 64'h5);
    @(posedge clk); #1;

    // Randomized operations with random result stalls
    for (int i = 0; i < 40; i++) begin
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 60; c++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
        if (sb.size() == 0 && bus.in_ready) break;
      end
      bus.out_ready = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (20) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_bla_sub.md
# serial_bla_sub

Nibble-serial borrow-lookahead subtractor computing `d = a - b - bin` over `width/4` clock cycles, one 4-bit group per cycle. It is the area-reduced inverse-operation companion to the team's parallel carry-lookahead adder, for datapaths where subtraction latency is tolerable but gate count is not. Operands enter and results leave through valid/ready handshakes.

## Interface
- `width`, default 32: operand/result width. Must be a multiple of 4 and ≥ 4. N = `width/4` nibbles.

- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `a` in `width`: minuend.
- `b` in `width`: subtrahend.
- `bin` in 1: borrow-in.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `d` out `width`: difference, mod 2^width.
- `bout` out 1: borrow-out. Equals 1 iff unsigned a < b + bin.
- `ovf` out 1 (only with SERIAL_SUB_OVF_EN): signed overflow.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. If `in_valid`, capture `a`, `b`, `bin` into internal registers, clear nibble counter, go to RUN.
  - RUN: each cycle process nibble k (k = 0..N-1, LSB first). k=N-1 → DONE.
  - DONE: `out_valid`=1. If `out_ready`, go to IDLE.
- Per-nibble arithmetic, with `br` = running borrow (initialised to captured `bin`):
  - `d[4k+3:4k] = (a_nib - b_nib - br) mod 16`.
  - `br_next` = 1 iff a_nib < b_nib + br.
- `br_next` is formed by lookahead, not by a ripple chain:
  - g_i = ~a_i & b_i; p_i = ~a_i | b_i.
  - G = g3 | p3&(g2 | p2&(g1 | p1&g0)); P = &p.
  - `br_next` = G | P&br.
- Result nibbles are written into the `d` register at position k. `bout` = final `br`.
- Inputs are sampled only on the accept cycle (`in_valid && in_ready`). Changes to `a`/`b`/`bin` afterwards have no effect.
- While in RUN or DONE, `in_valid` is ignored and no operand is lost: `in_ready`=0 makes the producer hold.
- Reset, including reset mid-RUN or mid-DONE:
  - State → IDLE, the in-flight operation is discarded.
  - All registers cleared: `d`=0, `bout`=0, `ovf`=0, `out_valid`=0, `in_ready`=1 (also during reset).

## Timing
- `in_ready` = (state==IDLE), decoded from the state register only. No combinational path from any input.
- `out_valid`, `d`, `bout`, `ovf` are registered outputs.
- `d`, `bout` and `ovf` are stable from the first `out_valid` cycle until the handshake completes.
- Latency: accept at edge t → nibbles written at edges t+1..t+N → `out_valid`=1 in the cycle following edge t+N.
- Result handshake at edge u (`out_valid && out_ready`) → IDLE, `in_ready`=1 after edge u.
- No result/accept overlap, so the next accept is at edge u+1 at the earliest.
- Peak throughput: one operation per N+2 cycles.
- Back-pressure: `out_ready`=0 holds DONE indefinitely with outputs frozen.
- During RUN, the `d` register contents are undefined to the consumer. Only DONE-state values are architecturally visible.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - Port `ovf` exists.
  - `ovf` = borrow into bit `width-1` XOR `bout`, captured during the last nibble. Equivalently, ovf=1 iff signed a − b − bin is not representable in `width` bits.
  - `ovf` is registered, with the same validity rules as `d`.
- `SERIAL_SUB_OVF_EN` undefined: port `ovf` and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use `width`=32 (N=8).
1. Basic: a=0x00000005, b=0x00000003, bin=0, accept at edge t → `out_valid` first high after edge t+8, d=0x00000002, bout=0.
2. Full borrow propagation: a=0x00000000, b=0x00000001, bin=0 → d=0xFFFFFFFF, bout=1.
3. Borrow-in: a=b=0x12345678, bin=1 → d=0xFFFFFFFF, bout=1. Same operands with bin=0 → d=0, bout=0.
4. Back-pressure:
   - Hold `out_ready`=0 for 5 cycles after `out_valid` rises, with `in_valid`=1 and new operands throughout → d and bout unchanged, `in_ready`=0, no second accept.
   - Raise `out_ready` → next accept exactly one cycle after the handshake, and the new result is correct.
5. Reset mid-operation: assert `rst_n`=0 asynchronously three cycles after accept → immediately `out_valid`=0, `in_ready`=1, d=0. After release, an accept of a=9, b=4 yields d=5.
6. With `SERIAL_SUB_OVF_EN` defined:
   - a=0x80000000, b=0x00000001, bin=0 → d=0x7FFFFFFF, bout=0, ovf=1.
   - a=0x00000003, b=0x00000001 → ovf=0.
